// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and bit-timing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int D_WIDTH_DEF      = 8;
    localparam int CLK_HZ           = 100_000_000;
    localparam int BAUD             = 6_250_000;
    localparam int CLKS_PER_BIT_DEF = CLK_HZ / BAUD;

    // Counter value at the centre of the start bit.
    function automatic int half_bit(input int cpb);
        return (cpb - 1) / 2;
    endfunction

endpackage

// File: rtl/rx_data_reg.sv
// Holding register for the received byte; loads only on a good stop bit.
module rx_data_reg
    import uart_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic [D_WIDTH-1:0] i_data,
    output logic [D_WIDTH-1:0] o_data
);

    logic [D_WIDTH-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_data <= '0;
        else if (i_enable)
            r_data <= i_data;
    end

    assign o_data = r_data;

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: synchronised line, edge-armed start detection, mid-bit sampling,
// one-cycle valid / frame-error strobes and a held output byte.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int D_WIDTH      = D_WIDTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx,
    output logic [D_WIDTH-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

    localparam logic [CW-1:0] HALF     = CW'(half_bit(CLKS_PER_BIT));
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(D_WIDTH - 1);

    logic               r_sync1;
    logic               r_rx_s;
    logic               r_rx_d;
    logic               w_fall;

    rx_state_e          r_state;
    rx_state_e          w_state_nxt;
    logic [CW-1:0]      r_clk_cnt;
    logic [CW-1:0]      w_clk_cnt_nxt;
    logic [IW-1:0]      r_bit_idx;
    logic [IW-1:0]      w_bit_idx_nxt;
    logic [D_WIDTH-1:0] r_shift;
    logic               w_sample;
    logic               w_good;
    logic               w_ferr;
    logic               r_valid;
    logic               r_frame_err;

    // Flops preset to 1 so a line that is idle at reset release is not seen as a start edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    assign w_fall = r_rx_d & ~r_rx_s;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_clk_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            if (w_sample)
                r_shift[r_bit_idx] <= r_rx_s;
            r_valid     <= w_good;
            r_frame_err <= w_ferr;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt + CW'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_sample      = 1'b0;
        w_good        = 1'b0;
        w_ferr        = 1'b0;
        case (r_state)
            IDLE: begin
                w_clk_cnt_nxt = '0;
                if (w_fall)
                    w_state_nxt = START;
            end
            START: begin
                if (r_clk_cnt == HALF) begin
                    w_state_nxt   = r_rx_s ? IDLE : DATA;
                    w_bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (r_clk_cnt == LAST) begin
                    w_sample      = 1'b1;
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == IDX_LAST)
                        w_state_nxt = STOP;
                    else
                        w_bit_idx_nxt = r_bit_idx + IW'(1);
                end
            end
            STOP: begin
                // Leave at mid-stop so the next start edge is never missed.
                if (r_clk_cnt == LAST) begin
                    w_state_nxt = IDLE;
                    w_good      = r_rx_s;
                    w_ferr      = ~r_rx_s;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_state_nxt != r_state)
            w_clk_cnt_nxt = '0;
    end

    rx_data_reg #(
        .D_WIDTH (D_WIDTH)
    ) u_data_reg (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (w_good),
        .i_data   (r_shift),
        .o_data   (o_data)
    );

    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: stimulus pushes expected pulses, a monitor pops and compares.
module tb_uart_rx_fsm;

    localparam int CPB = 16;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    uart_rx_fsm #(
        .CLKS_PER_BIT (CPB),
        .D_WIDTH      (8)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   valid_cyc[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    bit   prev_pulse = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic push_exp(input bit f, input logic [7:0] d);
        exp_t e;
        e.ferr = f;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (o_valid || o_frame_err) begin
            check("strobe_exclusive", {30'd0, o_valid && o_frame_err, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, o_valid, o_frame_err}, 32'd0);
            end else begin
                m_e = exp_q.pop_front();
                check("strobe_kind", {31'd0, o_frame_err}, {31'd0, m_e.ferr});
                check("strobe_data", {24'd0, o_data}, {24'd0, m_e.data});
            end
            if (o_valid)
                valid_cyc.push_back(cyc);
        end
        prev_pulse <= o_valid || o_frame_err;
    end

    task automatic send_bit(input logic b, input int n);
        i_rx = b;
        repeat (n) @(negedge i_clk);
    endtask

    // Start bit at nominal width; data and stop bits at bt clocks to model baud skew.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bt);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++)
            send_bit(d[i], bt);
        send_bit(stop, bt);
    endtask

    task automatic check_outputs(input string name, input logic [7:0] d, input logic busy);
        check({name, "_data"}, {24'd0, o_data}, {24'd0, d});
        check({name, "_busy"}, {31'd0, o_busy}, {31'd0, busy});
    endtask

    initial begin
        int diff;
        i_rst = 1'b0;
        i_rx  = 1'b1;
        repeat (3) @(negedge i_clk);
        check_outputs("reset", 8'h00, 1'b0);
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_ferr", {31'd0, o_frame_err}, 32'd0);
        i_rst = 1'b1;
        send_bit(1'b1, 10);

        // Single good frame
        push_exp(1'b0, 8'hA5);
        send_frame(8'hA5, 1'b1, CPB);
        send_bit(1'b1, 20);
        check_outputs("a5", 8'hA5, 1'b0);

        // Back-to-back frames with no idle gap
        push_exp(1'b0, 8'h00);
        push_exp(1'b0, 8'hFF);
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        send_bit(1'b1, 20);
        check("b2b_count", valid_cyc.size(), 32'd3);
        diff = (valid_cyc.size() >= 3) ? valid_cyc[2] - valid_cyc[1] : 0;
        check("b2b_spacing_ok", {31'd0, diff >= 159 && diff <= 161}, 32'd1);
        check_outputs("b2b", 8'hFF, 1'b0);

        // Short low glitch: START entered, then rejected at mid-bit
        send_bit(1'b0, 4);
        send_bit(1'b1, 4);
        check("glitch_in_start", {31'd0, o_busy}, 32'd1);
        send_bit(1'b1, 30);
        check_outputs("glitch", 8'hFF, 1'b0);

        // Bad stop bit, then line held low: no re-arm without a fresh 1->0 edge
        push_exp(1'b1, 8'hFF);
        send_frame(8'h3C, 1'b0, CPB);
        send_bit(1'b0, 20);
        check("break_no_rearm", {31'd0, o_busy}, 32'd0);
        send_bit(1'b0, 20);
        send_bit(1'b1, 30);
        check_outputs("ferr", 8'hFF, 1'b0);

        // Reset in the middle of frame 0x5A, while the line is high
        send_bit(1'b0, CPB);
        send_bit(1'b0, CPB);
        send_bit(1'b1, 8);
        check("pre_reset_busy", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        check_outputs("midrst", 8'h00, 1'b0);
        check("midrst_valid", {31'd0, o_valid}, 32'd0);
        check("midrst_ferr", {31'd0, o_frame_err}, 32'd0);
        send_bit(1'b1, 40);
        push_exp(1'b0, 8'h81);
        send_frame(8'h81, 1'b1, CPB);
        send_bit(1'b1, 20);
        check_outputs("post_rst", 8'h81, 1'b0);

        // Baud skew, fast and slow transmitter
        push_exp(1'b0, 8'h96);
        send_frame(8'h96, 1'b1, 15);
        send_bit(1'b1, 40);
        push_exp(1'b0, 8'h96);
        send_frame(8'h96, 1'b1, 17);
        send_bit(1'b1, 40);
        check_outputs("skew", 8'h96, 1'b0);

        check("pending_expected", exp_q.size(), 32'd0);
        check("total_valid", valid_cyc.size(), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
